// File: rtl/decode_rename_fifo.sv
// decode_rename_fifo
//   Multi-lane FIFO between decode and rename. Up to W ops are pushed and up to
//   W popped per cycle. Free space and occupancy are advertised per lane. A
//   commit flush empties the queue in one cycle.
// Ports
//   clk, rst (async, active low), flush
//   push side : data_in[W*DATA_WIDTH], data_in_valid[W], push, data_in_enable[W]
//   pop side  : data_out[W*DATA_WIDTH], data_out_valid[W], data_pop_valid[W], pop
//   status    : count, full, empty
// All outputs are decoded from registered pointers and storage only.
module decode_rename_fifo #(
  parameter int W          = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  output logic [W-1:0]              data_in_enable,
  input  logic [W*DATA_WIDTH-1:0]   data_in,
  input  logic [W-1:0]              data_in_valid,
  input  logic                      push,
  output logic [W*DATA_WIDTH-1:0]   data_out,
  output logic [W-1:0]              data_out_valid,
  input  logic [W-1:0]              data_pop_valid,
  input  logic                      pop,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         rptr, wptr, free, n_push, n_pop;
  logic [W-1:0]          push_acc, pop_acc;
  logic [AW-1:0]         widx [W];

  // Pointers carry a wrap bit, so the difference is the occupancy directly.
  assign count = wptr - rptr;
  assign free  = PW'(DEPTH) - count;
  assign full  = (count == PW'(DEPTH));
  assign empty = (count == '0);

  for (genvar i = 0; i < W; i++) begin : g_lane
    assign data_in_enable[i] = (free > PW'(i));
    assign data_out_valid[i] = (count > PW'(i));
    assign data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem[rptr[AW-1:0] + AW'(i)];
  end

  // data_in_enable is a thermometer mask, so every accepted lane's ordinal
  // among the accepted lanes is below the free space: no overflow check needed.
  assign push_acc = {W{push}} & data_in_valid & data_in_enable;
  assign pop_acc  = {W{pop}} & data_pop_valid & data_out_valid;

  // Compact accepted lanes into consecutive slots starting at wptr.
  always_comb begin
    n_push = '0;
    n_pop  = '0;
    for (int j = 0; j < W; j++) begin
      widx[j] = wptr[AW-1:0] + n_push[AW-1:0];
      if (push_acc[j]) n_push = n_push + PW'(1);
      if (pop_acc[j])  n_pop  = n_pop + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
    end else if (flush) begin
      rptr <= '0;
      wptr <= '0;
    end else begin
      wptr <= wptr + n_push;
      rptr <= rptr + n_pop;
    end
  end

  // Storage is not reset; only lanes flagged by data_out_valid are meaningful.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int j = 0; j < W; j++)
        if (push_acc[j]) mem[widx[j]] <= data_in[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_decode_rename_fifo.sv
module tb_decode_rename_fifo;
  localparam int W = 4, DEPTH = 16, DW = 128;

  logic              clk = 1'b0, rst = 1'b0, flush = 1'b0, push = 1'b0, pop = 1'b0;
  logic [W-1:0]      data_in_enable, data_in_valid = '0, data_out_valid, data_pop_valid = '0;
  logic [W*DW-1:0]   data_in = '0, data_out;
  logic [$clog2(DEPTH):0] count;
  logic              full, empty;

  decode_rename_fifo #(.W(W), .DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .data_in_enable(data_in_enable), .data_in(data_in), .data_in_valid(data_in_valid),
    .push(push), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_pop_valid(data_pop_valid), .pop(pop),
    .count(count), .full(full), .empty(empty));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, seq = 0, mcount = 0;
  logic [DW-1:0] q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [W-1:0] en, vl;
    for (int i = 0; i < W; i++) begin
      en[i] = (DEPTH - mcount) > i;
      vl[i] = mcount > i;
    end
    chk({tag, ".count"}, DW'(count), DW'(mcount));
    chk({tag, ".empty"}, DW'(empty), DW'(mcount == 0));
    chk({tag, ".full"}, DW'(full), DW'(mcount == DEPTH));
    chk({tag, ".in_enable"}, DW'(data_in_enable), DW'(en));
    chk({tag, ".out_valid"}, DW'(data_out_valid), DW'(vl));
    for (int i = 0; i < W && i < q.size(); i++)
      chk($sformatf("%s.lane%0d", tag, i), data_out[i*DW +: DW], q[i]);
  endtask

  // One clock of stimulus; the model is updated from its own start-of-cycle state.
  task automatic cyc(input string tag, input logic p, input logic [W-1:0] vm,
                     input logic po, input logic [W-1:0] pm, input logic fl);
    logic [DW-1:0] lane_v [W];
    int n_pop;
    seq++;
    for (int i = 0; i < W; i++) begin
      lane_v[i] = {96'(seq), 32'((i + 1) * 'h11)};
      data_in[i*DW +: DW] = lane_v[i];
    end
    push = p; data_in_valid = vm; pop = po; data_pop_valid = pm; flush = fl;
    n_pop = 0;
    if (po) for (int i = 0; i < W; i++) if (pm[i] && mcount > i) n_pop++;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; data_in_valid = '0; data_pop_valid = '0;
    if (fl) q.delete();
    else begin
      int start = mcount;
      for (int i = 0; i < n_pop; i++) void'(q.pop_front());
      if (p) for (int i = 0; i < W; i++)
        if (vm[i] && (DEPTH - start) > i) q.push_back(lane_v[i]);
    end
    mcount = q.size();
    check_all(tag);
  endtask

  initial begin
    #2;
    check_all("reset");
    @(posedge clk); #1 rst = 1'b1;
    cyc("idle", 0, '0, 0, '0, 0);
    cyc("pop_empty", 0, '0, 1, 4'b1111, 0);

    // fill to full, then one push that must be ignored
    for (int k = 0; k < 4; k++) cyc($sformatf("fill%0d", k), 1, 4'b1111, 0, '0, 0);
    chk("full_lane0_lowbyte", DW'(data_out[7:0]), DW'(8'h11));
    chk("full_lane3_lowbyte", DW'(data_out[3*DW +: 8]), DW'(8'h44));
    cyc("push_full", 1, 4'b1111, 0, '0, 0);
    chk("push_full_count", DW'(count), DW'(16));

    // count 14, push four -> only two fit
    cyc("pop2", 0, '0, 1, 4'b0011, 0);
    cyc("push_partial", 1, 4'b1111, 0, '0, 0);
    chk("partial_count", DW'(count), DW'(16));

    // drain to 4, then simultaneous push 2 / pop 3
    for (int k = 0; k < 3; k++) cyc($sformatf("drain%0d", k), 0, '0, 1, 4'b1111, 0);
    cyc("push_pop", 1, 4'b0011, 1, 4'b0111, 0);
    chk("push_pop_count", DW'(count), DW'(3));

    // non-prefix push mask compacts lanes 0 and 2
    cyc("nonprefix", 1, 4'b0101, 0, '0, 0);
    cyc("drain_np", 0, '0, 1, 4'b1111, 0);
    cyc("drain_np2", 0, '0, 1, 4'b1111, 0);

    // steady state across pointer wrap
    cyc("wrap_prime", 1, 4'b1111, 0, '0, 0);
    for (int k = 0; k < 10; k++) cyc($sformatf("wrap%0d", k), 1, 4'b1111, 1, 4'b1111, 0);
    chk("wrap_count", DW'(count), DW'(4));

    // count 9, flush with push and pop -> empty
    cyc("to8", 1, 4'b1111, 0, '0, 0);
    cyc("to9", 1, 4'b0001, 0, '0, 0);
    chk("nine", DW'(count), DW'(9));
    cyc("flush", 1, 4'b1111, 1, 4'b1111, 1);
    chk("flush_empty", DW'(empty), DW'(1));
    cyc("flush_empty_fifo", 0, '0, 0, '0, 1);

    // async reset mid-stream takes effect without a clock edge
    cyc("pre_rst", 1, 4'b1111, 0, '0, 0);
    push = 1'b1; data_in_valid = 4'b1111;
    #1 rst = 1'b0;
    #1;
    q.delete(); mcount = 0;
    check_all("rst_mid");
    push = 1'b0; data_in_valid = '0;
    @(posedge clk); #1 rst = 1'b1;
    cyc("post_rst", 1, 4'b0011, 0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
